regfile_wb_arbiter: RTL and testbench

Shares the register file's single synchronous write port between two writeback sources: port 0 (ALU/execute result) and port 1 (load/memory result). Each source hands over a (destination, data) pair through a valid/ready handshake. The pair is held in a one-entry per-port buffer and granted round-robin to a registered write-port output. The block also exports a pending-destination mask that issue logic uses to stall reads of registers with writes still in flight.

---
 rtl/regfile_wb_arbiter_if.sv | 42 ++++
 rtl/regfile_wb_arbiter.sv | 134 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter_if
// Brief    : Writeback request ports and register-file write port bundle for
//            the two-source writeback arbiter.
// Revision : 1.0
// ============================================================================
interface regfile_wb_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                        req0_valid;
  logic                        req0_ready;
  logic [ADDR_WIDTH-1:0]       req0_addr;
  logic [DATA_WIDTH-1:0]       req0_data;
  logic                        req1_valid;
  logic                        req1_ready;
  logic [ADDR_WIDTH-1:0]       req1_addr;
  logic [DATA_WIDTH-1:0]       req1_data;
  logic                        write_en;
  logic [ADDR_WIDTH-1:0]       write_addr;
  logic [DATA_WIDTH-1:0]       write_data;
  logic [(2**ADDR_WIDTH)-1:0]  pending_mask;
  logic [15:0]                 write_count;

  // Writeback sources and the observers of the register-file write port.
  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready,
    input  write_en, write_addr, write_data, pending_mask, write_count
  );

  // The arbiter itself.
  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready,
    output write_en, write_addr, write_data, pending_mask, write_count
  );
endinterface
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter
// Brief    : Round-robin arbiter sharing the register file's single write port
//            between the ALU (port 0) and load (port 1) writeback sources.
//            One-entry buffer per port, registered write port, and a mask of
//            destinations with writes still in flight.
// Revision : 1.0
// ============================================================================
module regfile_wb_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  wire logic           clk,
  input  wire logic           rst,
  regfile_wb_arbiter_if.slave bus
);
  localparam int c_NREGS = 2**ADDR_WIDTH;

  logic                  r_buf0_valid;
  logic [ADDR_WIDTH-1:0] r_buf0_addr;
  logic [DATA_WIDTH-1:0] r_buf0_data;
  logic                  r_buf1_valid;
  logic [ADDR_WIDTH-1:0] r_buf1_addr;
  logic [DATA_WIDTH-1:0] r_buf1_data;
  logic                  r_last_grant;
  logic                  r_write_en;
  logic [ADDR_WIDTH-1:0] r_write_addr;
  logic [DATA_WIDTH-1:0] r_write_data;
  logic [15:0]           r_write_count;

  logic                  w_grant0;
  logic                  w_grant1;
  logic                  w_ready0;
  logic                  w_ready1;
  logic                  w_keep0;
  logic                  w_keep1;
  logic [c_NREGS-1:0]    w_pending;

  // Round-robin pick among occupied buffers; a tie goes to the port that did not win last.
  always_comb begin
    w_grant0 = r_buf0_valid;
    w_grant1 = r_buf1_valid;
    if (r_buf0_valid && r_buf1_valid) begin
      w_grant0 = r_last_grant;
      w_grant1 = !r_last_grant;
    end
  end

  // A port is ready when its buffer is empty or draining this cycle; writes to r0 are swallowed.
  always_comb begin
    w_ready0 = !rst && (!r_buf0_valid || w_grant0);
    w_ready1 = !rst && (!r_buf1_valid || w_grant1);
    w_keep0  = bus.req0_valid && w_ready0 && (bus.req0_addr != '0);
    w_keep1  = bus.req1_valid && w_ready1 && (bus.req1_addr != '0);
  end

  // Port 0 buffer: reload on accept (even while draining), clear when granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf0_valid <= 1'b0;
      r_buf0_addr  <= '0;
      r_buf0_data  <= '0;
    end else if (w_keep0) begin
      r_buf0_valid <= 1'b1;
      r_buf0_addr  <= bus.req0_addr;
      r_buf0_data  <= bus.req0_data;
    end else if (w_grant0) begin
      r_buf0_valid <= 1'b0;
    end
  end

  // Port 1 buffer: same behaviour as port 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf1_valid <= 1'b0;
      r_buf1_addr  <= '0;
      r_buf1_data  <= '0;
    end else if (w_keep1) begin
      r_buf1_valid <= 1'b1;
      r_buf1_addr  <= bus.req1_addr;
      r_buf1_data  <= bus.req1_data;
    end else if (w_grant1) begin
      r_buf1_valid <= 1'b0;
    end
  end

  // Registered write port and round-robin history; address/data hold when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_write_en   <= 1'b0;
      r_write_addr <= '0;
      r_write_data <= '0;
      r_last_grant <= 1'b1;
    end else begin
      r_write_en <= w_grant0 || w_grant1;
      if (w_grant0) begin
        r_write_addr <= r_buf0_addr;
        r_write_data <= r_buf0_data;
        r_last_grant <= 1'b0;
      end else if (w_grant1) begin
        r_write_addr <= r_buf1_addr;
        r_write_data <= r_buf1_data;
        r_last_grant <= 1'b1;
      end
    end
  end

  // Count cycles with the write port active, sticking at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_write_count <= '0;
    end else if (r_write_en && (r_write_count != 16'hFFFF)) begin
      r_write_count <= r_write_count + 16'd1;
    end
  end

  // Destinations still owed a write: both buffers plus the write port.
  always_comb begin
    w_pending = '0;
    if (r_buf0_valid) w_pending[r_buf0_addr] = 1'b1;
    if (r_buf1_valid) w_pending[r_buf1_addr] = 1'b1;
    if (r_write_en)   w_pending[r_write_addr] = 1'b1;
  end

  assign bus.req0_ready   = w_ready0;
  assign bus.req1_ready   = w_ready1;
  assign bus.write_en     = r_write_en;
  assign bus.write_addr   = r_write_addr;
  assign bus.write_data   = r_write_data;
  assign bus.pending_mask = w_pending;
  assign bus.write_count  = r_write_count;
endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wb_arbiter
// Brief    : Scoreboard bench for regfile_wb_arbiter. Drivers push accepted
//            writebacks into per-port queues; a monitor pops them as writes
//            appear and checks the pending mask against the queue contents.
// Revision : 1.0
// ============================================================================
module tb_regfile_wb_arbiter;
  localparam int c_DW = 32;
  localparam int c_AW = 5;

  typedef struct {
    logic [c_AW-1:0] addr;
    logic [c_DW-1:0] data;
  } entry_t;

  typedef struct {
    int              port;
    int              cyc;
    logic [c_AW-1:0] addr;
  } wlog_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  regfile_wb_arbiter_if #(.DATA_WIDTH(c_DW), .ADDR_WIDTH(c_AW)) bus();

  regfile_wb_arbiter #(.DATA_WIDTH(c_DW), .ADDR_WIDTH(c_AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int      vec = 0;
  int      miss = 0;
  int      cyc = 0;
  int      writes_seen = 0;
  int      pushes = 0;
  bit      mon_en = 1'b0;
  entry_t  q0[$];
  entry_t  q1[$];
  wlog_t   wlog[$];
  logic [31:0] m_exp;
  logic        m_hit;
  wlog_t       m_rec;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int log_port(input int i);
    return (wlog.size() > i) ? wlog[i].port : -1;
  endfunction
  function automatic int log_cyc(input int i);
    return (wlog.size() > i) ? wlog[i].cyc : -100;
  endfunction
  function automatic int log_addr(input int i);
    return (wlog.size() > i) ? int'(wlog[i].addr) : -1;
  endfunction

  // Monitor: every write must be the oldest outstanding entry of one port;
  // the mask must equal the set of destinations still owed a write.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      m_exp = '0;
      if (bus.write_en === 1'b1) begin
        writes_seen++;
        m_hit = 1'b0;
        if (q0.size() > 0 && q0[0].addr == bus.write_addr && q0[0].data == bus.write_data) begin
          m_hit = 1'b1;
          m_exp[q0[0].addr] = 1'b1;
          m_rec.port = 0; m_rec.cyc = cyc; m_rec.addr = q0[0].addr;
          wlog.push_back(m_rec);
          void'(q0.pop_front());
        end else if (q1.size() > 0 && q1[0].addr == bus.write_addr && q1[0].data == bus.write_data) begin
          m_hit = 1'b1;
          m_exp[q1[0].addr] = 1'b1;
          m_rec.port = 1; m_rec.cyc = cyc; m_rec.addr = q1[0].addr;
          wlog.push_back(m_rec);
          void'(q1.pop_front());
        end
        chk("write_matches_oldest_entry", {31'd0, m_hit}, 64'd1);
      end
      foreach (q0[i]) m_exp[q0[i].addr] = 1'b1;
      foreach (q1[i]) m_exp[q1[i].addr] = 1'b1;
      chk("pending_mask", bus.pending_mask, m_exp);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Hand one writeback over a port; called and returns at posedge+1.
  task automatic send(input int p, input logic [c_AW-1:0] a, input logic [c_DW-1:0] d,
                      output int waits, output int acc);
    entry_t e;
    waits = 0;
    acc = -1;
    if (p == 0) begin
      bus.req0_valid = 1'b1; bus.req0_addr = a; bus.req0_data = d;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_addr = a; bus.req1_data = d;
    end
    forever begin
      @(negedge clk); #1;
      if ((p == 0) ? bus.req0_ready : bus.req1_ready) break;
      waits++;
      if (waits > 50) break;
    end
    if (waits > 50) begin
      vec++; miss++;
      $display("FAIL accept_timeout: port %0d addr %0d not accepted within 50 cycles", p, a);
    end else begin
      acc = cyc + 1;
      if (a != '0) begin
        e.addr = a; e.data = d;
        if (p == 0) q0.push_back(e); else q1.push_back(e);
        pushes++;
      end
    end
    @(posedge clk); #1;
    if (p == 0) bus.req0_valid = 1'b0; else bus.req1_valid = 1'b0;
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    rst = 1'b1;
    q0.delete(); q1.delete(); wlog.delete();
    writes_seen = 0; pushes = 0;
    idle(2);
    rst = 1'b0;
    #1;
    chk("ready0_after_rst", {63'd0, bus.req0_ready}, 64'd1);
    chk("ready1_after_rst", {63'd0, bus.req1_ready}, 64'd1);
    mon_en = 1'b1;
    idle(1);
  endtask

  int w, acc, wa, wb, wc, wd, aa, ab, ac, ad;

  initial begin
    bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.req0_data = '0;
    bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_data = '0;
    idle(2);

    // Reset state
    chk("rst_write_en",     {63'd0, bus.write_en}, 64'd0);
    chk("rst_write_addr",   {59'd0, bus.write_addr}, 64'd0);
    chk("rst_write_data",   {32'd0, bus.write_data}, 64'd0);
    chk("rst_pending_mask", {32'd0, bus.pending_mask}, 64'd0);
    chk("rst_write_count",  {48'd0, bus.write_count}, 64'd0);
    chk("rst_ready0",       {63'd0, bus.req0_ready}, 64'd0);
    chk("rst_ready1",       {63'd0, bus.req1_ready}, 64'd0);
    do_reset();

    // Single write: two-edge latency
    send(0, 5'd5, 32'hDEADBEEF, w, acc);
    idle(3);
    chk("single_writes", wlog.size(), 1);
    chk("single_latency", log_cyc(0) - acc, 1);
    chk("single_count", {48'd0, bus.write_count}, 64'd1);

    // r0 drop: handshake completes, nothing else happens
    send(1, 5'd0, 32'h1234, w, acc);
    chk("r0_wait", w, 0);
    idle(3);
    chk("r0_no_write", writes_seen, 1);
    chk("r0_count", {48'd0, bus.write_count}, 64'd1);
    chk("r0_mask", {32'd0, bus.pending_mask}, 64'd0);

    // Tie after reset: port 0 first, port 1 stalls one cycle
    do_reset();
    fork
      begin
        send(0, 5'd3, 32'h0000_0303, wa, aa);
        send(0, 5'd6, 32'h0000_0606, wb, ab);
      end
      begin
        send(1, 5'd4, 32'h0000_0404, wc, ac);
        send(1, 5'd7, 32'h0000_0707, wd, ad);
      end
    join
    idle(3);
    chk("tie_writes", wlog.size(), 4);
    chk("tie_first_addr", log_addr(0), 3);
    chk("tie_second_addr", log_addr(1), 4);
    chk("tie_consecutive", log_cyc(1) - log_cyc(0), 1);
    chk("tie_p0_second_wait", wb, 0);
    chk("tie_p1_second_wait", wd, 1);

    // Sustained contention: strict alternation, one write per cycle
    do_reset();
    fork
      for (int i = 1; i <= 8; i++) send(0, 5'(i), $urandom, wa, aa);
      for (int i = 9; i <= 16; i++) send(1, 5'(i), $urandom, wc, ac);
    join
    idle(4);
    chk("sustain_writes", wlog.size(), 16);
    for (int i = 0; i < 16; i++) begin
      chk("sustain_port_alternates", log_port(i), i % 2);
      if (i > 0) chk("sustain_consecutive", log_cyc(i) - log_cyc(i - 1), 1);
    end
    chk("sustain_count", {48'd0, bus.write_count}, 64'd16);

    // Back-to-back on a single port
    wlog.delete();
    for (int i = 0; i < 4; i++) begin
      send(0, 5'(20 + i), $urandom, w, acc);
      chk("b2b_ready_wait", w, 0);
    end
    idle(3);
    chk("b2b_writes", wlog.size(), 4);
    for (int i = 1; i < 4; i++) chk("b2b_consecutive", log_cyc(i) - log_cyc(i - 1), 1);
    chk("b2b_count", {48'd0, bus.write_count}, 64'd20);

    // Reset mid-stream with both buffers full and a write on the port.
    // Port 0 won last, so the tie goes to port 1 (addr 9) and it reloads with 11.
    mon_en = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_addr = 5'd7; bus.req0_data = 32'h77;
    bus.req1_valid = 1'b1; bus.req1_addr = 5'd9; bus.req1_data = 32'h99;
    idle(1);
    bus.req0_addr = 5'd10; bus.req0_data = 32'hAA;
    bus.req1_addr = 5'd11; bus.req1_data = 32'hBB;
    idle(1);
    chk("mid_write_en", {63'd0, bus.write_en}, 64'd1);
    chk("mid_write_addr", {59'd0, bus.write_addr}, 64'd9);
    chk("mid_mask", {32'd0, bus.pending_mask}, 64'h0000_0A80);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_write_en", {63'd0, bus.write_en}, 64'd0);
    chk("mid_rst_mask", {32'd0, bus.pending_mask}, 64'd0);
    chk("mid_rst_count", {48'd0, bus.write_count}, 64'd0);
    chk("mid_rst_ready0", {63'd0, bus.req0_ready}, 64'd0);
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    q0.delete(); q1.delete(); wlog.delete();
    writes_seen = 0; pushes = 0;
    idle(2);
    rst = 1'b0;
    mon_en = 1'b1;
    idle(4);
    chk("post_rst_no_write", writes_seen, 0);
    chk("post_rst_count", {48'd0, bus.write_count}, 64'd0);

    // Randomized traffic on both ports, including r0 writes and idle gaps
    fork
      for (int i = 0; i < 40; i++) begin
        send(0, 5'($urandom_range(0, 31)), $urandom, wa, aa);
        idle($urandom_range(0, 2));
      end
      for (int i = 0; i < 40; i++) begin
        send(1, 5'($urandom_range(0, 31)), $urandom, wc, ac);
        idle($urandom_range(0, 2));
      end
    join
    idle(5);
    chk("rand_q0_drained", q0.size(), 0);
    chk("rand_q1_drained", q1.size(), 0);
    chk("rand_count", {48'd0, bus.write_count}, 64'(pushes));
    chk("rand_writes_seen", writes_seen, pushes);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire
